// File: rtl/sub_pipe_arbiter_pkg.sv
// Shared types and sizing for the subtractor-pipeline arbiter.
// Purely declarative: no latency, no backpressure.
// rr_pick gives the first valid index at or above ptr, wrapping around.
package sub_arb_pkg;

    localparam int NUM_REQ      = 4;
    localparam int C_DATA_WIDTH = 32;
    localparam int TAG_BITS     = 8;
    localparam int MAX_INFLIGHT = 8;
    localparam int ID_BITS      = $clog2(NUM_REQ);
    localparam int CNT_BITS     = $clog2(MAX_INFLIGHT) + 1;

    typedef struct packed {
        logic [ID_BITS-1:0]  id;
        logic [TAG_BITS-1:0] tag;
    } id_entry_t;

    function automatic logic [ID_BITS-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                   input logic [ID_BITS-1:0] ptr);
        logic [ID_BITS-1:0] idx;
        rr_pick = ptr;
        // Walk from the farthest offset down so the nearest valid index wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_BITS'((int'(ptr) + k) % NUM_REQ);
            if (valid[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/sub_pipe_arbiter_if.sv
// Requester, response and subtractor-side signals of the arbiter.
// No logic: slave = arbiter view, master = surrounding kernel/subtractor view.
// Flow control is AXI-S style valid/ready on every channel.
interface sub_pipe_arbiter_if;
    import sub_arb_pkg::*;

    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0][C_DATA_WIDTH-1:0]   req_a;
    logic [NUM_REQ-1:0][C_DATA_WIDTH-1:0]   req_b;
    logic [NUM_REQ-1:0][TAG_BITS-1:0]       req_tag;
    logic [NUM_REQ-1:0]                     req_ready;

    logic [NUM_REQ-1:0]                     rsp_valid;
    logic [C_DATA_WIDTH-1:0]                rsp_data;
    logic [TAG_BITS-1:0]                    rsp_tag;
    logic [NUM_REQ-1:0]                     rsp_ready;

    logic [1:0]                             sub_tvalid;
    logic [1:0][C_DATA_WIDTH-1:0]           sub_tdata;
    logic [1:0]                             sub_tready;
    logic                                   sub_m_tvalid;
    logic [C_DATA_WIDTH-1:0]                sub_m_tdata;
    logic                                   sub_m_tready;

    logic [CNT_BITS-1:0]                    inflight;
    logic                                   err_orphan;

    modport slave (
        input  req_valid, req_a, req_b, req_tag, rsp_ready, sub_tready, sub_m_tvalid, sub_m_tdata,
        output req_ready, rsp_valid, rsp_data, rsp_tag, sub_tvalid, sub_tdata, sub_m_tready,
               inflight, err_orphan
    );

    modport master (
        output req_valid, req_a, req_b, req_tag, rsp_ready, sub_tready, sub_m_tvalid, sub_m_tdata,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, sub_tvalid, sub_tdata, sub_m_tready,
               inflight, err_orphan
    );

endinterface

// File: rtl/sub_pipe_arbiter_id_fifo.sv
// In-order {requester, tag} FIFO with fall-through head, one entry per issued op.
// Latency: push visible at head the cycle after; pop takes effect at the clock edge.
// Backpressure: full/empty exported; pushes when full and pops when empty are ignored.
module sub_arb_id_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sub_pipe_arbiter.sv
// Round-robin share of one subtractor pipeline among NUM_REQ requesters, results routed back in order.
// Latency: 1 cycle request->grant, issue the cycle after; result path is combinational (zero added).
// Backpressure: grant locks until sub_tready; issue stalls at MAX_INFLIGHT; result waits on rsp_ready[id].
module sub_pipe_arbiter
    import sub_arb_pkg::*;
(
    input  logic              aclk,
    input  logic              aresetn,
    sub_pipe_arbiter_if.slave bus
);
    localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_REQ - 1);

    logic [ID_BITS-1:0]  grant_q;
    logic [ID_BITS-1:0]  rr_ptr_q;
    logic                lock_q;
    logic                err_q;

    id_entry_t           push_ent;
    id_entry_t           head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_BITS-1:0] fifo_count;

    logic                sub_vld;
    logic                issue;
    logic                retire;

    assign sub_vld           = lock_q && !fifo_full;
    assign bus.sub_tvalid    = {2{sub_vld}};
    assign bus.sub_tdata[0]  = bus.req_a[grant_q];
    assign bus.sub_tdata[1]  = bus.req_b[grant_q];
    assign issue             = sub_vld && bus.sub_tready[0];
    assign bus.req_ready     = issue ? (NUM_REQ'(1) << grant_q) : '0;

    assign push_ent          = '{id: grant_q, tag: bus.req_tag[grant_q]};

    // With nothing outstanding any result is an orphan and is drained rather than stalled.
    assign bus.rsp_valid     = (bus.sub_m_tvalid && !fifo_empty) ? (NUM_REQ'(1) << head.id) : '0;
    assign bus.rsp_data      = bus.sub_m_tdata;
    assign bus.rsp_tag       = head.tag;
    assign bus.sub_m_tready  = fifo_empty ? bus.sub_m_tvalid : bus.rsp_ready[head.id];
    assign retire            = bus.sub_m_tvalid && bus.sub_m_tready && !fifo_empty;

    assign bus.inflight      = fifo_count;
    assign bus.err_orphan    = err_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant_q  <= '0;
            rr_ptr_q <= '0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            assert (!lock_q || bus.req_valid[grant_q]);
            if (issue) begin
                lock_q   <= 1'b0;
                rr_ptr_q <= (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
            end else if (!lock_q && |bus.req_valid) begin
                lock_q  <= 1'b1;
                grant_q <= rr_pick(bus.req_valid, rr_ptr_q);
            end
            if (bus.sub_m_tvalid && fifo_empty) err_q <= 1'b1;
        end
    end

    sub_arb_id_fifo #(
        .WIDTH ($bits(id_entry_t)),
        .DEPTH (MAX_INFLIGHT)
    ) u_id_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .push     (issue),
        .push_dat (push_ent),
        .pop      (retire),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_sub_pipe_arbiter.sv
// Bench for sub_pipe_arbiter with a behavioural mod-97, 2-cycle subtractor and per-port response scoreboards.
module tb_sub_pipe_arbiter;
    import sub_arb_pkg::*;

    localparam int P   = 97;
    localparam int LAT = 2;

    typedef struct { int a; int b; int tag; } op_t;
    typedef struct { int data; int tag; }     rsp_t;
    typedef struct { int data; int rdy; }     pipe_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    sub_pipe_arbiter_if bus ();

    sub_pipe_arbiter dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus.slave)
    );

    op_t   port_q [NUM_REQ][$];
    rsp_t  exp_q  [NUM_REQ][$];
    pipe_t pipe_q [$];
    int    issue_log [$];
    int    rsp_log [$];
    int    rsp_tag_log [$];

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int n_issued = 0;

    logic [NUM_REQ-1:0]      rsp_mask     = '1;
    logic                    tready_en    = 1'b1;
    logic                    force_orphan = 1'b0;
    bit                      issued_now;
    bit                      retired_now;
    logic [NUM_REQ-1:0]      last_rsp_valid;
    logic [C_DATA_WIDTH-1:0] last_rsp_data;
    logic [TAG_BITS-1:0]     last_rsp_tag;

    function automatic int modsub(input int a, input int b);
        return ((a - b) % P + P) % P;
    endfunction

    task automatic add_op(input int p, input int a, input int b, input int tag);
        op_t  o;
        rsp_t r;
        o = '{a: a, b: b, tag: tag};
        r = '{data: modsub(a, b), tag: tag};
        port_q[p].push_back(o);
        exp_q[p].push_back(r);
    endtask

    // One clock: drive at the falling edge, then score the handshakes that the next rising edge commits.
    task automatic run_cycle();
        int   p;
        op_t  o;
        rsp_t r;
        pipe_t e;
        @(negedge aclk);
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i] = (port_q[i].size() > 0);
            if (port_q[i].size() > 0) begin
                bus.req_a[i]   = 32'(port_q[i][0].a);
                bus.req_b[i]   = 32'(port_q[i][0].b);
                bus.req_tag[i] = 8'(port_q[i][0].tag);
            end
        end
        bus.sub_tready = {2{tready_en}};
        bus.rsp_ready  = rsp_mask;
        if (force_orphan) begin
            bus.sub_m_tvalid = 1'b1;
            bus.sub_m_tdata  = '0;
        end else if (pipe_q.size() > 0 && pipe_q[0].rdy <= cyc) begin
            bus.sub_m_tvalid = 1'b1;
            bus.sub_m_tdata  = 32'(pipe_q[0].data);
        end else begin
            bus.sub_m_tvalid = 1'b0;
        end
        #1;
        issued_now  = 0;
        retired_now = 0;
        checks++;
        if (bus.sub_tvalid[1] !== bus.sub_tvalid[0]) begin
            errors++;
            $display("FAIL sub_tvalid_pair: got %b required equal bits", bus.sub_tvalid);
        end
        if (bus.sub_tvalid[0] && bus.sub_tready[0]) begin
            p = -1;
            for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) p = i;
            checks++;
            if (p < 0 || bus.req_ready !== (NUM_REQ'(1) << p) || port_q[p].size() == 0) begin
                errors++;
                $display("FAIL issue_ready: got req_ready=%b required one-hot on a pending port", bus.req_ready);
            end else begin
                o = port_q[p].pop_front();
                checks++;
                if (bus.sub_tdata[0] !== 32'(o.a) || bus.sub_tdata[1] !== 32'(o.b)) begin
                    errors++;
                    $display("FAIL issue_data: got a=%0d b=%0d required a=%0d b=%0d",
                             bus.sub_tdata[0], bus.sub_tdata[1], o.a, o.b);
                end
                e = '{data: modsub(o.a, o.b), rdy: cyc + LAT};
                pipe_q.push_back(e);
                issue_log.push_back(p);
                n_issued++;
                issued_now = 1;
            end
        end else begin
            checks++;
            if (bus.req_ready !== '0) begin
                errors++;
                $display("FAIL idle_ready: got req_ready=%b required 0", bus.req_ready);
            end
        end
        if (bus.sub_m_tvalid && bus.sub_m_tready && !force_orphan) begin
            void'(pipe_q.pop_front());
            p = -1;
            for (int i = 0; i < NUM_REQ; i++) if (bus.rsp_valid[i]) p = i;
            checks++;
            if (p < 0 || bus.rsp_valid !== (NUM_REQ'(1) << p) || exp_q[p].size() == 0) begin
                errors++;
                $display("FAIL rsp_route: got rsp_valid=%b required one-hot on a port with pending ops",
                         bus.rsp_valid);
            end else begin
                r = exp_q[p].pop_front();
                checks++;
                if (bus.rsp_data !== 32'(r.data) || bus.rsp_tag !== 8'(r.tag)) begin
                    errors++;
                    $display("FAIL rsp_payload: port %0d got data=%0d tag=%0h required data=%0d tag=%0h",
                             p, bus.rsp_data, bus.rsp_tag, r.data, r.tag);
                end
                rsp_log.push_back(p);
                rsp_tag_log.push_back(int'(bus.rsp_tag));
                last_rsp_valid = bus.rsp_valid;
                last_rsp_data  = bus.rsp_data;
                last_rsp_tag   = bus.rsp_tag;
                retired_now    = 1;
            end
        end
        cyc++;
    endtask

    function automatic bit all_idle();
        bit b;
        b = (pipe_q.size() == 0) && (bus.inflight == '0);
        for (int i = 0; i < NUM_REQ; i++) b &= (port_q[i].size() == 0) && (exp_q[i].size() == 0);
        return b;
    endfunction

    task automatic wait_idle(input int budget, input string name);
        bit done;
        done = all_idle();
        for (int i = 0; i < budget && !done; i++) begin
            run_cycle();
            done = all_idle();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: not idle after %0d cycles", name, budget);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REQ; i++) begin
            port_q[i].delete();
            exp_q[i].delete();
        end
        pipe_q.delete();
        issue_log.delete();
        rsp_log.delete();
        rsp_tag_log.delete();
        n_issued         = 0;
        bus.sub_m_tvalid = 1'b0;
    endtask

    task automatic apply_reset();
        aresetn      = 1'b0;
        force_orphan = 1'b0;
        rsp_mask     = '1;
        tready_en    = 1'b1;
        clear_model();
        run_cycle();
        run_cycle();
        aresetn = 1'b1;
        run_cycle();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        run_cycle();
        checks += 6;
        if (bus.inflight !== '0)     begin errors++; $display("FAIL rst_inflight: got %0d required 0", bus.inflight); end
        if (bus.err_orphan !== 1'b0) begin errors++; $display("FAIL rst_err_orphan: got %b required 0", bus.err_orphan); end
        if (bus.sub_tvalid !== 2'b00) begin errors++; $display("FAIL rst_sub_tvalid: got %b required 00", bus.sub_tvalid); end
        if (bus.req_ready !== '0)    begin errors++; $display("FAIL rst_req_ready: got %b required 0", bus.req_ready); end
        if (bus.rsp_valid !== '0)    begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", bus.rsp_valid); end
        if (bus.sub_m_tready !== 1'b0) begin errors++; $display("FAIL rst_sub_m_tready: got %b required 0", bus.sub_m_tready); end
        aresetn = 1'b1;
        run_cycle();
    endtask

    task automatic test_single();
        add_op(0, 10, 20, 5);
        wait_idle(50, "single");
        checks += 4;
        if (last_rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_valid: got %b required 0001", last_rsp_valid); end
        if (last_rsp_data !== 32'd87)   begin errors++; $display("FAIL single_data: got %0d required 87", last_rsp_data); end
        if (last_rsp_tag !== 8'd5)      begin errors++; $display("FAIL single_tag: got %0d required 5", last_rsp_tag); end
        if (issue_log.size() != 1 || issue_log[0] != 0) begin
            errors++;
            $display("FAIL single_issue: got %0d issues required exactly one from port 0", issue_log.size());
        end
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NUM_REQ; p++) add_op(p, 10 * p + r + 5, p, 16 * p + r);
        wait_idle(200, "fairness");
        checks++;
        if (issue_log.size() != 8) begin
            errors++;
            $display("FAIL fair_count: got %0d issues required 8", issue_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (issue_log[i] != i % NUM_REQ) begin
                    errors++;
                    $display("FAIL fair_order[%0d]: got port %0d required %0d", i, issue_log[i], i % NUM_REQ);
                end
            end
        end
    endtask

    task automatic test_full();
        apply_reset();
        rsp_mask = '0;
        for (int k = 0; k < 12; k++) add_op(k % NUM_REQ, k + 20, k, 8'h40 + k);
        repeat (40) run_cycle();
        checks += 4;
        if (n_issued != 8)            begin errors++; $display("FAIL full_issued: got %0d required 8", n_issued); end
        if (bus.inflight !== 4'd8)    begin errors++; $display("FAIL full_inflight: got %0d required 8", bus.inflight); end
        if (bus.sub_tvalid !== 2'b00) begin errors++; $display("FAIL full_sub_tvalid: got %b required 00", bus.sub_tvalid); end
        if (bus.sub_m_tready !== 1'b0) begin errors++; $display("FAIL full_sub_m_tready: got %b required 0", bus.sub_m_tready); end
        rsp_mask = '1;
        wait_idle(300, "full_drain");
        checks++;
        if (n_issued != 12) begin errors++; $display("FAIL full_release: got %0d issued required 12", n_issued); end
    endtask

    task automatic test_routing();
        int n0;
        issue_log.delete();
        rsp_log.delete();
        rsp_tag_log.delete();
        n0 = n_issued;
        add_op(2, 50, 7, 8'hA1);
        for (int i = 0; i < 20 && n_issued == n0; i++) run_cycle();
        add_op(1, 3, 90, 8'hB2);
        wait_idle(60, "routing");
        checks += 2;
        if (issue_log.size() != 2 || issue_log[0] != 2 || issue_log[1] != 1) begin
            errors++;
            $display("FAIL route_issue: got %0d issues required ports 2 then 1", issue_log.size());
        end
        if (rsp_log.size() != 2 || rsp_log[0] != 2 || rsp_log[1] != 1 ||
            rsp_tag_log[0] != 'hA1 || rsp_tag_log[1] != 'hB2) begin
            errors++;
            $display("FAIL route_rsp: got %0d responses required port2/A1 then port1/B2", rsp_log.size());
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        rsp_mask = 4'b0111;
        add_op(3, 60, 10, 8'h33);
        for (int i = 0; i < 20 && !bus.sub_m_tvalid; i++) run_cycle();
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            checks += 3;
            if (bus.sub_m_tready !== 1'b0) begin errors++; $display("FAIL bp_tready[%0d]: got %b required 0", i, bus.sub_m_tready); end
            if (bus.rsp_valid !== 4'b1000) begin errors++; $display("FAIL bp_valid[%0d]: got %b required 1000", i, bus.rsp_valid); end
            if (bus.rsp_data !== 32'd50 || bus.rsp_tag !== 8'h33) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got data=%0d tag=%0h required 50/33", i, bus.rsp_data, bus.rsp_tag);
            end
        end
        tready_en = 1'b0;
        add_op(0, 40, 45, 8'h44);
        repeat (3) run_cycle();
        tready_en = 1'b1;
        rsp_mask  = '1;
        run_cycle();
        checks += 2;
        if (!(issued_now && retired_now)) begin
            errors++;
            $display("FAIL bp_same_cycle: got issue=%0d retire=%0d required both", issued_now, retired_now);
        end
        run_cycle();
        if (bus.inflight !== 4'd1) begin errors++; $display("FAIL bp_inflight: got %0d required 1", bus.inflight); end
        wait_idle(40, "backpressure");
    endtask

    task automatic test_orphan_reset();
        force_orphan = 1'b1;
        run_cycle();
        checks += 2;
        if (bus.sub_m_tready !== 1'b1) begin errors++; $display("FAIL orphan_drain: got %b required 1", bus.sub_m_tready); end
        if (bus.rsp_valid !== '0)      begin errors++; $display("FAIL orphan_rsp: got %b required 0", bus.rsp_valid); end
        force_orphan = 1'b0;
        run_cycle();
        checks++;
        if (bus.err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b required 1", bus.err_orphan); end
        rsp_mask = '0;
        for (int p = 0; p < NUM_REQ; p++) add_op(p, p + 30, p, p);
        repeat (6) run_cycle();
        checks++;
        if (bus.inflight == '0) begin errors++; $display("FAIL burst_inflight: got 0 required nonzero"); end
        aresetn = 1'b0;
        clear_model();
        #1;
        checks += 6;
        if (bus.inflight !== '0)       begin errors++; $display("FAIL mid_rst_inflight: got %0d required 0", bus.inflight); end
        if (bus.err_orphan !== 1'b0)   begin errors++; $display("FAIL mid_rst_err: got %b required 0", bus.err_orphan); end
        if (bus.sub_tvalid !== 2'b00)  begin errors++; $display("FAIL mid_rst_sub_tvalid: got %b required 00", bus.sub_tvalid); end
        if (bus.req_ready !== '0)      begin errors++; $display("FAIL mid_rst_req_ready: got %b required 0", bus.req_ready); end
        if (bus.rsp_valid !== '0)      begin errors++; $display("FAIL mid_rst_rsp_valid: got %b required 0", bus.rsp_valid); end
        if (bus.sub_m_tready !== 1'b0) begin errors++; $display("FAIL mid_rst_sub_m_tready: got %b required 0", bus.sub_m_tready); end
        rsp_mask = '1;
        run_cycle();
        run_cycle();
        aresetn = 1'b1;
        add_op(3, 9, 1, 8'h03);
        add_op(0, 8, 2, 8'h00);
        wait_idle(60, "post_reset");
        checks++;
        if (issue_log.size() != 2 || issue_log[0] != 0 || issue_log[1] != 3) begin
            errors++;
            $display("FAIL post_rst_rr: got %0d issues required port 0 then 3", issue_log.size());
        end
    endtask

    initial begin
        bus.req_valid    = '0;
        bus.req_a        = '0;
        bus.req_b        = '0;
        bus.req_tag      = '0;
        bus.rsp_ready    = '1;
        bus.sub_tready   = '0;
        bus.sub_m_tvalid = 1'b0;
        bus.sub_m_tdata  = '0;
        test_reset();
        test_single();
        test_fairness();
        test_full();
        test_routing();
        test_backpressure();
        test_orphan_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
